// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared RV32 ALU op codes, M-extension funct codes and ALU request helper
package rv32i_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLT  = 4'd2,
    ALU_SLTU = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_AND  = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9,
    ALU_EQ   = 4'd10,
    ALU_NEQ  = 4'd11,
    ALU_GE   = 4'd12,
    ALU_GEU  = 4'd13
  } alu_op_e;

  // funct3[1:0] of the RV32M divide group: bit0 = unsigned, bit1 = remainder
  localparam logic [1:0] FUNCT_DIV  = 2'b00;
  localparam logic [1:0] FUNCT_DIVU = 2'b01;
  localparam logic [1:0] FUNCT_REM  = 2'b10;
  localparam logic [1:0] FUNCT_REMU = 2'b11;

  typedef struct packed {
    alu_op_e     op;
    logic [31:0] a;
    logic [31:0] b;
  } alu_req_t;

  function automatic alu_req_t alu_req(input alu_op_e op, input logic [31:0] a,
                                       input logic [31:0] b);
    alu_req_t r;
    r.op = op;
    r.a  = a;
    r.b  = b;
    return r;
  endfunction

endpackage

// File: rtl/rv32i_div_seq.sv
// rtl/rv32i_div_seq.sv - RV32M DIV/DIVU/REM/REMU sequencer driving the shared ALU
module rv32i_div_seq
  import rv32i_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [1:0]      i_funct,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result,
  output logic [XLEN-1:0] o_alu_a,
  output logic [XLEN-1:0] o_alu_b,
  output logic [3:0]      o_alu_op,
  input  logic [XLEN-1:0] i_alu_y
);

  typedef enum logic [2:0] {
    S_IDLE, S_NEG_A, S_NEG_B, S_CMP, S_SUB, S_FIX, S_DONE
  } state_e;

  state_e          r_state;
  alu_req_t        r_alu;
  logic [31:0]     r_q;
  logic [31:0]     r_r;
  logic [31:0]     r_d;
  logic [4:0]      r_cnt;
  logic            r_qb;
  logic            r_sgn;
  logic            r_rem;
  logic            r_neg;

  logic [31:0]     w_d_abs;
  logic            w_qb;
  logic [31:0]     w_r_next;

  // ALU request is registered: each state programs the op the next state consumes
  assign o_alu_op = r_alu.op;
  assign o_alu_a  = r_alu.a;
  assign o_alu_b  = r_alu.b;

  assign w_d_abs  = (r_sgn && r_d[31]) ? i_alu_y : r_d;
  // R[31] shifted out of R' is the 33rd bit: R' >= D is guaranteed when it is set
  assign w_qb     = i_alu_y[0] | r_r[31];
  assign w_r_next = r_qb ? i_alu_y : r_alu.a;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_alu    <= alu_req(ALU_ADD, '0, '0);
      r_q      <= '0;
      r_r      <= '0;
      r_d      <= '0;
      r_cnt    <= '0;
      r_qb     <= 1'b0;
      r_sgn    <= 1'b0;
      r_rem    <= 1'b0;
      r_neg    <= 1'b0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_result <= '0;
    end else begin
      o_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_q    <= i_rs1;
            r_d    <= i_rs2;
            r_r    <= '0;
            r_cnt  <= '0;
            r_qb   <= 1'b0;
            r_sgn  <= ~i_funct[0];
            r_rem  <= i_funct[1];
            r_neg  <= ~i_funct[0] & (i_funct[1] ? i_rs1[31] : (i_rs1[31] ^ i_rs2[31]));
            o_busy <= 1'b1;
            if (i_rs2 == '0) begin
              o_result <= i_funct[1] ? i_rs1 : '1;
              o_done   <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_alu   <= alu_req(ALU_SUB, '0, i_rs1);
              r_state <= S_NEG_A;
            end
          end
        end
        S_NEG_A: begin
          if (r_sgn && r_q[31]) r_q <= i_alu_y;
          r_alu   <= alu_req(ALU_SUB, '0, r_d);
          r_state <= S_NEG_B;
        end
        S_NEG_B: begin
          r_d     <= w_d_abs;
          r_alu   <= alu_req(ALU_GEU, {r_r[30:0], r_q[31]}, w_d_abs);
          r_state <= S_CMP;
        end
        S_CMP: begin
          r_qb    <= w_qb;
          r_q     <= {r_q[30:0], w_qb};
          r_alu   <= alu_req(ALU_SUB, r_alu.a, r_d);
          r_state <= S_SUB;
        end
        S_SUB: begin
          r_r <= w_r_next;
          if (r_cnt == 5'd31) begin
            r_alu   <= alu_req(ALU_SUB, '0, r_rem ? w_r_next : r_q);
            r_state <= S_FIX;
          end else begin
            r_cnt   <= r_cnt + 5'd1;
            r_alu   <= alu_req(ALU_GEU, {w_r_next[30:0], r_q[31]}, r_d);
            r_state <= S_CMP;
          end
        end
        S_FIX: begin
          o_result <= r_neg ? i_alu_y : r_alu.b;
          o_done   <= 1'b1;
          r_alu    <= alu_req(ALU_ADD, '0, '0);
          r_state  <= S_DONE;
        end
        S_DONE: begin
          o_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          o_busy  <= 1'b0;
          r_alu   <= alu_req(ALU_ADD, '0, '0);
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_div_seq.sv
// tb/tb_rv32i_div_seq.sv - randomized self-checking bench for rv32i_div_seq with an ALU model
module tb_rv32i_div_seq;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic [1:0]  i_funct;
  logic [31:0] i_rs1;
  logic [31:0] i_rs2;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_result;
  logic [31:0] o_alu_a;
  logic [31:0] o_alu_b;
  logic [3:0]  o_alu_op;
  logic [31:0] i_alu_y;

  int vectors = 0;
  int miscompares = 0;

  rv32i_div_seq #(.XLEN(32)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_funct(i_funct),
    .i_rs1(i_rs1), .i_rs2(i_rs2), .o_busy(o_busy), .o_done(o_done),
    .o_result(o_result), .o_alu_a(o_alu_a), .o_alu_b(o_alu_b),
    .o_alu_op(o_alu_op), .i_alu_y(i_alu_y)
  );

  always #5 i_clk = ~i_clk;

  // parent's shared ALU, only the ops this block may request
  always_comb begin
    i_alu_y = '0;
    case (o_alu_op)
      4'd0:    i_alu_y = o_alu_a + o_alu_b;
      4'd1:    i_alu_y = o_alu_a - o_alu_b;
      4'd13:   i_alu_y = {31'b0, o_alu_a >= o_alu_b};
      default: i_alu_y = '0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_div(input logic [1:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    if (b == 32'd0) return f[1] ? a : 32'hFFFF_FFFF;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f[1] ? 32'd0 : 32'h8000_0000;
    case (f)
      2'b00:   return 32'($signed(a) / $signed(b));
      2'b01:   return a / b;
      2'b10:   return 32'($signed(a) % $signed(b));
      default: return a % b;
    endcase
  endfunction

  task automatic run_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                        input int rst_at, input int restart_at);
    logic [31:0] exp;
    int          exp_lat;
    int          n;
    exp     = ref_div(f, a, b);
    exp_lat = (b == 32'd0) ? 1 : 68;
    @(negedge i_clk);
    i_start = 1'b1;
    i_funct = f;
    i_rs1   = a;
    i_rs2   = b;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    i_rs1   = $urandom;
    i_rs2   = $urandom;
    check("busy_after_accept", {31'b0, o_busy}, 32'd1);
    if (b != 32'd0) begin
      check("neg_a_op", {28'b0, o_alu_op}, 32'd1);
      check("neg_a_b", o_alu_b, a);
    end
    n = 1;
    while (!o_done && n < 100) begin
      if (n == restart_at) begin
        i_start = 1'b1;
        i_funct = ~f;
        i_rs1   = 32'h5;
        i_rs2   = 32'd0;
      end
      if (n == rst_at) i_rst = 1'b1;
      @(posedge i_clk);
      #1;
      n++;
      i_start = 1'b0;
      if (i_rst) begin
        i_rst = 1'b0;
        check("rst_busy", {31'b0, o_busy}, 32'd0);
        check("rst_result", o_result, 32'd0);
        check("rst_alu", {28'b0, o_alu_op} | o_alu_a | o_alu_b, 32'd0);
      end
    end
    if (rst_at > 0) begin
      check("rst_no_done", 32'(n), 32'd100);
    end else begin
      check("latency", 32'(n), 32'(exp_lat));
      check("result", o_result, exp);
      check("done_busy", {31'b0, o_busy}, 32'd1);
      @(posedge i_clk);
      #1;
      check("done_pulse", {31'b0, o_done}, 32'd0);
      check("idle_busy", {31'b0, o_busy}, 32'd0);
      check("result_hold", o_result, exp);
      check("idle_alu", {28'b0, o_alu_op} | o_alu_a | o_alu_b, 32'd0);
    end
  endtask

  logic [1:0]  df[12] = '{2'b01, 2'b11, 2'b00, 2'b10, 2'b00, 2'b10,
                          2'b01, 2'b11, 2'b01, 2'b11, 2'b00, 2'b10};
  logic [31:0] da[12] = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                          32'h8000_0000, 32'h8000_0000, 32'h1234, 32'h1234,
                          32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234, 32'hFFFF_FFF9};
  logic [31:0] db[12] = '{32'd7, 32'd7, 32'd2, 32'd2,
                          32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0,
                          32'h8000_0001, 32'h8000_0001, 32'd0, 32'd0};

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    i_rst   = 1'b1;
    i_start = 1'b0;
    i_funct = 2'b00;
    i_rs1   = '0;
    i_rs2   = '0;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    check("reset_busy", {31'b0, o_busy}, 32'd0);
    check("reset_done", {31'b0, o_done}, 32'd0);
    check("reset_result", o_result, 32'd0);
    check("reset_alu", {28'b0, o_alu_op} | o_alu_a | o_alu_b, 32'd0);

    for (int i = 0; i < 12; i++) run_op(df[i], da[i], db[i], 0, 0);

    run_op(2'b01, 32'd100, 32'd7, 0, 9);
    run_op(2'b00, 32'hDEAD_BEEF, 32'h0000_1234, 29, 0);

    @(negedge i_clk);
    i_rst   = 1'b1;
    i_start = 1'b1;
    i_funct = 2'b01;
    i_rs1   = 32'd9;
    i_rs2   = 32'd3;
    @(posedge i_clk);
    #1;
    i_rst   = 1'b0;
    i_start = 1'b0;
    check("rst_start_busy", {31'b0, o_busy}, 32'd0);
    @(posedge i_clk);
    #1;
    check("rst_start_dropped", {31'b0, o_busy}, 32'd0);

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = $urandom;
        1:       rb = 32'($urandom_range(0, 15));
        2:       rb = 32'h0 - 32'($urandom_range(1, 9));
        default: rb = $urandom >> $urandom_range(0, 31);
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      run_op(2'($urandom_range(0, 3)), ra, rb, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
